stopwatch_core: RTL
===================

Name: stopwatch_core

Overview:
- Consumer end of the clock divider's one-second tick. Counts MM:SS in BCD on each tick, under a start/pause/clear/load control FSM.
- Feeds four BCD digits plus status flags to the seven-segment display path, which is clocked from the divider's scan output.
- Supports count-up (stopwatch) and count-down (timer) modes, with terminal-count detection.

Parameters:
- MAX_MIN, 99, highest minute value reached in up mode (legal range 1..99); up-count terminal value is MAX_MIN:59.

Ports:
- clk  input  1  system clock (100 MHz); every flop is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sec_tick  input  1  one-clk-wide pulse, once per second, from the divider.
- start_stop  input  1  one-clk pulse (already debounced/edge-detected); toggles run/pause.
- clear  input  1  one-clk pulse; returns to 00:00 and IDLE.
- load  input  1  one-clk pulse; loads load_val.
- load_val  input  16  BCD {M1,M0,S1,S0}.
- dir  input  1  0 = count up, 1 = count down; sampled only on the RUN entry cycle.
- digits  output  16  BCD {M1,M0,S1,S0}, registered.
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.

Behaviour:
- States:
  - IDLE, RUN, PAUSE, DONE.
  - Reset (rst=1 on a rising edge) forces IDLE, digits=16'h0000, running=0, done=0, and latched direction=up. Reset overrides every other input in the same cycle.
- Input priority per cycle: rst > clear > load > start_stop > sec_tick.
- clear, from any state: next state IDLE, digits=0000.
- load:
  - Accepted only in IDLE, PAUSE or DONE; ignored in RUN.
  - If legal BCD (each digit <=9, S1 <=5, minutes <= MAX_MIN): digits <= load_val and next state is PAUSE.
  - If illegal: ignored, no state change.
- start_stop:
  - IDLE or PAUSE -> RUN, latching dir on that cycle.
  - RUN -> PAUSE.
  - Ignored in DONE.
  - Entering RUN in down mode with digits=0000 goes straight to DONE instead.
  - Entering RUN in up mode with digits=MAX_MIN:59 goes straight to DONE instead.
- sec_tick acts only in RUN, and only if no higher-priority input is active that cycle. A tick coincident with start_stop is dropped.
- Up step:
  - S0 9->0 with carry into S1.
  - S1 5->0 with carry into M0.
  - M0 9->0 with carry into M1.
  - On reaching MAX_MIN:59, next state is DONE.
- Down step:
  - S0 0->9 with borrow from S1.
  - S1 0->5 with borrow from M0.
  - M0 0->9 with borrow from M1.
  - On reaching 00:00, next state is DONE.
- No wrap-around in either direction: DONE holds digits frozen; further ticks are ignored.
- Latency:
  - digits changes on the clk edge after the edge that samples sec_tick (1 cycle).
  - running and done are registered and change on the same edge as the state register.
- dir changes while in RUN have no effect until the next RUN entry.
- Ticks arriving in IDLE, PAUSE or DONE are discarded, not accumulated.

Test Plan:
- Reset: rst=1 for 2 cycles mid-RUN at 12:34 -> digits=0000, running=0, done=0 on the edge after rst sampled.
- Up count:
  - From IDLE, pulse start_stop (dir=0), then 61 ticks -> digits=0101.
  - Pulse start_stop -> running=0.
  - A further tick -> digits unchanged.
- Carry chain:
  - load 09:59, start_stop (dir=0), one tick -> 10:00.
  - With MAX_MIN=99: load 99:58, start_stop, one tick -> 99:59, done=1.
  - A further tick -> still 99:59.
- Down timer:
  - load 01:00, start_stop (dir=1), one tick -> 00:59.
  - 59 more ticks -> 00:00, done=1, running=0.
  - start_stop -> stays DONE.
  - clear -> IDLE, 0000.
- Illegal load and priority:
  - load 16'h0060 in PAUSE -> ignored, digits unchanged.
  - load during RUN -> ignored.
  - clear+load+start_stop in the same cycle -> IDLE, 0000.
- Coincident tick:
  - In RUN at 00:10 (up), start_stop and sec_tick in the same cycle -> PAUSE, digits stay 00:10.
  - Next start_stop+tick -> RUN, digits still 00:10.

Source files
------------

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch/timer driven by a one-second tick.
//   clk, rst     : system clock, synchronous active-high reset
//   sec_tick     : one-cycle pulse per second
//   start_stop   : one-cycle pulse, toggles run/pause
//   clear        : one-cycle pulse, back to IDLE at 00:00
//   load         : one-cycle pulse, loads load_val if it is legal BCD
//   load_val     : {M1,M0,S1,S0} BCD preset
//   dir          : 0 = count up, 1 = count down (latched on RUN entry)
//   digits       : {M1,M0,S1,S0} BCD count, registered
//   running      : high while in RUN
//   done         : high while in DONE (terminal count reached)
module stopwatch_core #(
  parameter int unsigned MAX_MIN = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sec_tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dir,
  output logic [15:0] digits,
  output logic        running,
  output logic        done
);

  localparam logic [3:0]  MAX_M1  = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MAX_M0  = 4'(MAX_MIN % 10);
  localparam logic [15:0] TERM_UP = {MAX_M1, MAX_M0, 4'h5, 4'h9};
  localparam logic [6:0]  MAX_MIN7 = 7'(MAX_MIN);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t      state, state_n;
  logic [15:0] digits_n;
  logic        dir_q, dir_n;
  logic        running_n, done_n;

  logic        load_legal;
  logic [6:0]  load_mins;
  logic [15:0] inc_val, dec_val;

  // Load legality: every digit decimal, tens-of-seconds <= 5, minutes <= MAX_MIN
  always_comb begin
    load_mins  = 7'(load_val[15:12]) * 7'd10 + 7'(load_val[11:8]);
    load_legal = (load_val[15:12] <= 4'd9) && (load_val[11:8] <= 4'd9) &&
                 (load_val[7:4] <= 4'd5) && (load_val[3:0] <= 4'd9) &&
                 (load_mins <= MAX_MIN7);
  end

  // BCD increment with carry S0 -> S1 -> M0 -> M1
  always_comb begin
    inc_val = digits;
    if (digits[3:0] == 4'd9) begin
      inc_val[3:0] = '0;
      if (digits[7:4] == 4'd5) begin
        inc_val[7:4] = '0;
        if (digits[11:8] == 4'd9) begin
          inc_val[11:8]  = '0;
          inc_val[15:12] = digits[15:12] + 4'd1;
        end else begin
          inc_val[11:8] = digits[11:8] + 4'd1;
        end
      end else begin
        inc_val[7:4] = digits[7:4] + 4'd1;
      end
    end else begin
      inc_val[3:0] = digits[3:0] + 4'd1;
    end
  end

  // BCD decrement with borrow S0 -> S1 -> M0 -> M1
  always_comb begin
    dec_val = digits;
    if (digits[3:0] == 4'd0) begin
      dec_val[3:0] = 4'd9;
      if (digits[7:4] == 4'd0) begin
        dec_val[7:4] = 4'd5;
        if (digits[11:8] == 4'd0) begin
          dec_val[11:8]  = 4'd9;
          dec_val[15:12] = digits[15:12] - 4'd1;
        end else begin
          dec_val[11:8] = digits[11:8] - 4'd1;
        end
      end else begin
        dec_val[7:4] = digits[7:4] - 4'd1;
      end
    end else begin
      dec_val[3:0] = digits[3:0] - 4'd1;
    end
  end

  // State register (also holds the datapath that moves with it)
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      digits  <= '0;
      dir_q   <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      digits  <= digits_n;
      dir_q   <= dir_n;
      running <= running_n;
      done    <= done_n;
    end
  end

  // Next state; the if/else chain encodes clear > load > start_stop > sec_tick.
  // An ignored load (in RUN or illegal) does not block lower-priority inputs.
  always_comb begin
    state_n  = state;
    digits_n = digits;
    dir_n    = dir_q;
    if (clear) begin
      state_n  = IDLE;
      digits_n = '0;
    end else if (load && (state != RUN) && load_legal) begin
      state_n  = PAUSE;
      digits_n = load_val;
    end else if (start_stop) begin
      unique case (state)
        IDLE, PAUSE: begin
          dir_n = dir;
          if (dir ? (digits == 16'h0000) : (digits == TERM_UP))
            state_n = DONE;
          else
            state_n = RUN;
        end
        RUN:     state_n = PAUSE;
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end else if (sec_tick && (state == RUN)) begin
      digits_n = dir_q ? dec_val : inc_val;
      if (dir_q ? (dec_val == 16'h0000) : (inc_val == TERM_UP))
        state_n = DONE;
    end
  end

  // Output decode from the next state so flags change with the state register
  always_comb begin
    running_n = (state_n == RUN);
    done_n    = (state_n == DONE);
  end

endmodule
